// File: rtl/sipo_pkg.sv
// Shared types and helpers for the SIPO deserializer and its bit counter.
package sipo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shiftregister_sipo_if.sv
// Serial input, parallel output handshake and status bundle of the SIPO deserializer.
interface shiftregister_sipo_if #(
  parameter int WIDTH = 4
);
  logic             Serial_In;
  logic             Frame_Start;
  logic             Parallel_Ready;
  logic             Overrun_Clear;
  logic [WIDTH-1:0] Parallel_Out;
  logic             Parallel_Valid;
  logic             Busy;
  logic             Overrun;
  logic             Parity_Error;

  modport master (
    output Serial_In, Frame_Start, Parallel_Ready, Overrun_Clear,
    input  Parallel_Out, Parallel_Valid, Busy, Overrun, Parity_Error
  );

  modport slave (
    input  Serial_In, Frame_Start, Parallel_Ready, Overrun_Clear,
    output Parallel_Out, Parallel_Valid, Busy, Overrun, Parity_Error
  );
endinterface

// File: rtl/sipo_bit_counter.sv
// Frame bit counter: loads 1 on frame start, increments per bit, flags bit WIDTH-1.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = cnt_w(WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load1_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load1_i)    cnt_d = CW'(1);
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign tc_o    = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shiftregister_sipo.sv
// Serial-in/parallel-out deserializer with valid/ready output and sticky overrun.
// Define SIPO_PARITY_CHECK_EN to receive and check a trailing even-parity bit per frame.
module shiftregister_sipo
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                Clk,
  input logic                Reset,
  shiftregister_sipo_if.slave bus
);

  localparam int CW        = cnt_w(WIDTH);
  localparam int FIRST_POS = LSB_FIRST ? 0 : WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic [CW-1:0]    cnt;
  logic             tc, load1, inc, commit;
  logic [WIDTH-1:0] word_c, placed_c;
  int               pos_c;

  function automatic logic [WIDTH-1:0] place(input logic [WIDTH-1:0] w, input int p,
                                             input logic b);
    logic [WIDTH-1:0] r;
    r = w;
    for (int i = 0; i < WIDTH; i++) if (i == p) r[i] = b;
    return r;
  endfunction

  sipo_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk_i  (Clk),
    .rst_i  (Reset),
    .load1_i(load1),
    .inc_i  (inc),
    .count_o(cnt),
    .tc_o   (tc)
  );

  assign pos_c    = LSB_FIRST ? int'(cnt) : (WIDTH - 1 - int'(cnt));
  assign placed_c = place(shreg_q, pos_c, bus.Serial_In);

  // Frame_Start always wins: it restarts assembly from any state.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    word_c  = shreg_q;
    commit  = 1'b0;
    load1   = 1'b0;
    inc     = 1'b0;
    if (bus.Frame_Start) begin
      shreg_d = place({WIDTH{1'b0}}, FIRST_POS, bus.Serial_In);
      load1   = 1'b1;
      state_d = ST_SHIFT;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          inc     = 1'b1;
          shreg_d = placed_c;
          if (tc) begin
`ifdef SIPO_PARITY_CHECK_EN
            state_d = ST_PARITY;
`else
            commit  = 1'b1;
            word_c  = placed_c;
            state_d = ST_IDLE;
`endif
          end
        end
`ifdef SIPO_PARITY_CHECK_EN
        ST_PARITY: begin
          commit  = 1'b1;
          state_d = ST_IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    out_d = commit ? word_c : out_q;
    vld_d = commit | (vld_q & ~bus.Parallel_Ready);
    ovr_d = (commit & vld_q & ~bus.Parallel_Ready) | (ovr_q & ~bus.Overrun_Clear);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef SIPO_PARITY_CHECK_EN
  logic perr_q, perr_d;

  assign perr_d = commit ? (^shreg_q ^ bus.Serial_In) : perr_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) perr_q <= 1'b0;
    else       perr_q <= perr_d;
  end

  assign bus.Parity_Error = perr_q;
`else
  assign bus.Parity_Error = 1'b0;
`endif

  assign bus.Parallel_Out   = out_q;
  assign bus.Parallel_Valid = vld_q;
  assign bus.Overrun        = ovr_q;
  assign bus.Busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shiftregister_sipo.sv
// Bench for shiftregister_sipo: directed frames then random traffic against a frame-level model.
module tb_shiftregister_sipo;

  localparam int W = 4;
`ifdef SIPO_PARITY_CHECK_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  shiftregister_sipo_if #(.WIDTH(W)) bl ();
  shiftregister_sipo_if #(.WIDTH(W)) bm ();

  shiftregister_sipo #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (.Clk(Clk), .Reset(Reset), .bus(bl));
  shiftregister_sipo #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (.Clk(Clk), .Reset(Reset), .bus(bm));

  int n_ast  = 0;
  int n_fail = 0;

  int          q[$];
  bit          act;
  logic [W-1:0] m_wl, m_wm;
  bit          m_vld, m_ovr, m_perr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_ast++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    act = 0; m_wl = '0; m_wm = '0; m_vld = 0; m_ovr = 0; m_perr = 0;
  endtask

  task automatic model_edge(input bit fs, input bit si, input bit rdy, input bit oc);
    bit com;
    int wl, wm, par;
    com = 0; wl = 0; wm = 0; par = 0;
    if (fs) begin
      q.delete();
      q.push_back(int'(si));
      act = 1;
    end else if (act) begin
      q.push_back(int'(si));
    end
    if (act && q.size() == FLEN) begin
      com = 1;
      act = 0;
      for (int i = 0; i < W; i++) begin
        wl  = wl + (q[i] << i);
        wm  = wm + (q[i] << (W - 1 - i));
        par = par ^ q[i];
      end
      if (FLEN > W) par = par ^ q[W];
    end
    if (com) begin
      if (m_vld && !rdy) m_ovr = 1;
      else if (oc)       m_ovr = 0;
      m_vld = 1;
      m_wl  = W'(wl);
      m_wm  = W'(wm);
`ifdef SIPO_PARITY_CHECK_EN
      m_perr = (par != 0);
`endif
    end else begin
      if (oc)  m_ovr = 0;
      if (rdy) m_vld = 0;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_out_l"}, 32'(bl.Parallel_Out), 32'(m_wl));
    chk({ph, "_vld_l"}, 32'(bl.Parallel_Valid), 32'(m_vld));
    chk({ph, "_busy_l"}, 32'(bl.Busy), 32'(act));
    chk({ph, "_ovr_l"}, 32'(bl.Overrun), 32'(m_ovr));
    chk({ph, "_perr_l"}, 32'(bl.Parity_Error), 32'(m_perr));
    chk({ph, "_out_m"}, 32'(bm.Parallel_Out), 32'(m_wm));
    chk({ph, "_vld_m"}, 32'(bm.Parallel_Valid), 32'(m_vld));
  endtask

  task automatic step(input string ph, input bit fs, input bit si, input bit rdy, input bit oc);
    bl.Frame_Start = fs; bl.Serial_In = si; bl.Parallel_Ready = rdy; bl.Overrun_Clear = oc;
    bm.Frame_Start = fs; bm.Serial_In = si; bm.Parallel_Ready = rdy; bm.Overrun_Clear = oc;
    @(posedge Clk);
    model_edge(fs, si, rdy, oc);
    #1;
    check_all(ph);
  endtask

  // b[i] is the i-th transmitted data bit; pflip corrupts the parity bit.
  task automatic send_frame(input string ph, input logic [W-1:0] b, input bit rdy, input bit pflip);
    for (int i = 0; i < W; i++) step(ph, (i == 0), b[i], rdy, 1'b0);
`ifdef SIPO_PARITY_CHECK_EN
    step(ph, 1'b0, (^b) ^ pflip, rdy, 1'b0);
`else
    if (pflip) chk({ph, "_pflip_unused"}, 32'(bl.Parity_Error), 32'd0);
`endif
  endtask

  initial begin
    bl.Frame_Start = 0; bl.Serial_In = 0; bl.Parallel_Ready = 0; bl.Overrun_Clear = 0;
    bm.Frame_Start = 0; bm.Serial_In = 0; bm.Parallel_Ready = 0; bm.Overrun_Clear = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_all("reset");
    Reset = 1'b0;

    // bits 1,0,1,0 with Ready=1
    send_frame("t1", 4'b0101, 1'b1, 1'b0);
    chk("t1_word", 32'(bl.Parallel_Out), 32'h5);
    chk("t1_vld", 32'(bl.Parallel_Valid), 32'd1);
    chk("t1_busy", 32'(bl.Busy), 32'd0);
    step("t1_idle", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_vld_drop", 32'(bl.Parallel_Valid), 32'd0);

    // back-to-back frames with Ready=0, then overrun clear
    send_frame("t2a", 4'b0110, 1'b0, 1'b0);
    chk("t2_word1", 32'(bl.Parallel_Out), 32'h6);
    send_frame("t2b", 4'b1111, 1'b0, 1'b0);
    chk("t2_word2", 32'(bl.Parallel_Out), 32'hF);
    chk("t2_ovr", 32'(bl.Overrun), 32'd1);
    step("t2_clr", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_ovr_clr", 32'(bl.Overrun), 32'd0);
    chk("t2_word_kept", 32'(bl.Parallel_Out), 32'hF);
    step("t2_take", 1'b0, 1'b0, 1'b1, 1'b0);

    // abort on edge 3, new frame 0,1,0,1
    step("t3_ab", 1'b1, 1'b1, 1'b1, 1'b0);
    step("t3_ab", 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame("t3", 4'b1010, 1'b1, 1'b0);
    chk("t3_word", 32'(bl.Parallel_Out), 32'hA);

    // serial 1,0,0,0: LSB-first 0001, MSB-first 1000
    send_frame("t4", 4'b0001, 1'b1, 1'b0);
    chk("t4_msb_word", 32'(bm.Parallel_Out), 32'h8);
    chk("t4_lsb_word", 32'(bl.Parallel_Out), 32'h1);

    // asynchronous reset after two bits
    step("t5_pre", 1'b1, 1'b1, 1'b0, 1'b0);
    step("t5_pre", 1'b0, 1'b1, 1'b0, 1'b0);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    check_all("t5_async");
    chk("t5_busy0", 32'(bl.Busy), 32'd0);
    #4 Reset = 1'b0;
    send_frame("t5", 4'b0011, 1'b1, 1'b0);
    chk("t5_word", 32'(bl.Parallel_Out), 32'h3);

`ifdef SIPO_PARITY_CHECK_EN
    send_frame("p0", 4'b0101, 1'b1, 1'b0);
    chk("p0_perr", 32'(bl.Parity_Error), 32'd0);
    send_frame("p1", 4'b0101, 1'b1, 1'b1);
    chk("p1_perr", 32'(bl.Parity_Error), 32'd1);
    chk("p1_word", 32'(bl.Parallel_Out), 32'h5);
`endif

    for (int k = 0; k < 400; k++) begin
      step("rnd", ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_ast, n_fail);
    $finish;
  end

endmodule
